// File: rtl/ip_tx_hdr_insert.sv
// rtl/ip_tx_hdr_insert.sv - transmit-side IPv4 header insertion and line realignment
//
// Purpose:
//   Accepts one 20-byte IPv4 header per packet and the packet payload as a
//   line stream. Emits header followed by payload on one output stream. Every
//   payload line is shifted down by 20 bytes, and the low 20 bytes spill into
//   the next output line through carry_q. A payload whose last line does not
//   leave room for the spilled bytes gets one extra TAIL line.
//
// Ports (byte 0 of any line sits at the MSB):
//   clk, rst                  clock, synchronous active-high reset
//   src_ip_tx_hdr_val/_rdy    header channel handshake (ready only in IDLE)
//   src_ip_tx_hdr             160-bit IPv4 header, ihl == 5
//   src_ip_tx_data_val/_rdy   payload line handshake
//   src_ip_tx_data/_last      payload line and end-of-packet marker
//   src_ip_tx_padbytes        invalid low-order bytes on the last payload line
//   ip_tx_dst_val/dst_ip_tx_rdy  output line handshake
//   ip_tx_dst_data/_last      output line and end-of-packet marker
//   ip_tx_dst_padbytes        invalid bytes on the last output line, else 0
//
// Optional feature macro: IP_TX_CHKSUM_EN
//   Defined:   the header checksum field is recomputed from the latched header.
//   Undefined: the header passes through unchanged and no adders are built.

module ip_tx_hdr_insert #(
  parameter int DATA_WIDTH     = 256,
  parameter int DATA_BYTES     = DATA_WIDTH / 8,
  parameter int PADBYTES_WIDTH = $clog2(DATA_BYTES),
  localparam int IP_HDR_W      = 160
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      src_ip_tx_hdr_val,
  output logic                      ip_tx_src_hdr_rdy,
  input  logic [IP_HDR_W-1:0]       src_ip_tx_hdr,
  input  logic                      src_ip_tx_data_val,
  output logic                      ip_tx_src_data_rdy,
  input  logic [DATA_WIDTH-1:0]     src_ip_tx_data,
  input  logic                      src_ip_tx_last,
  input  logic [PADBYTES_WIDTH-1:0] src_ip_tx_padbytes,
  output logic                      ip_tx_dst_val,
  input  logic                      dst_ip_tx_rdy,
  output logic [DATA_WIDTH-1:0]     ip_tx_dst_data,
  output logic                      ip_tx_dst_last,
  output logic [PADBYTES_WIDTH-1:0] ip_tx_dst_padbytes
);

  localparam int HDR_BYTES = IP_HDR_W / 8;
  localparam int BODY_W    = DATA_WIDTH - IP_HDR_W;
  localparam logic [PADBYTES_WIDTH-1:0] PAD_HDR       = PADBYTES_WIDTH'(HDR_BYTES);
  localparam logic [PADBYTES_WIDTH-1:0] PAD_TAIL_BASE = PADBYTES_WIDTH'(DATA_BYTES - HDR_BYTES);

  typedef enum logic [1:0] {S_IDLE, S_FIRST, S_BODY, S_TAIL} state_t;

  state_t                      state_q, state_d;
  logic [IP_HDR_W-1:0]         hdr_q, hdr_d;
  logic [IP_HDR_W-1:0]         carry_q, carry_d;
  logic [PADBYTES_WIDTH-1:0]   tail_pad_q, tail_pad_d;
  logic [IP_HDR_W-1:0]         hdr_out;

`ifdef IP_TX_CHKSUM_EN
  logic [19:0] sum;
  logic [16:0] fold1;
  logic [15:0] fold2;

  // One's-complement sum of the nine non-checksum words (word 5 is the
  // checksum field at bytes 10-11). Nine 16-bit words fit in 20 bits; two
  // end-around folds are enough to absorb every carry.
  always_comb begin
    sum = '0;
    for (int w = 0; w < 10; w++) begin
      if (w != 5) sum = sum + 20'(hdr_q[IP_HDR_W-1-16*w -: 16]);
    end
    fold1   = 17'(sum[15:0]) + 17'(sum[19:16]);
    fold2   = fold1[15:0] + 16'(fold1[16]);
    hdr_out = hdr_q;
    hdr_out[79:64] = ~fold2;
  end
`else
  assign hdr_out = hdr_q;
`endif

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    hdr_q      <= hdr_d;
    carry_q    <= carry_d;
    tail_pad_q <= tail_pad_d;
  end

  always_comb begin
    state_d            = state_q;
    hdr_d              = hdr_q;
    carry_d            = carry_q;
    tail_pad_d         = tail_pad_q;
    ip_tx_src_hdr_rdy  = 1'b0;
    ip_tx_src_data_rdy = 1'b0;
    ip_tx_dst_val      = 1'b0;
    ip_tx_dst_data     = '0;
    ip_tx_dst_last     = 1'b0;
    ip_tx_dst_padbytes = '0;

    case (state_q)
      S_IDLE: begin
        ip_tx_src_hdr_rdy = 1'b1;
        if (src_ip_tx_hdr_val) begin
          hdr_d   = src_ip_tx_hdr;
          state_d = S_FIRST;
        end
      end

      S_FIRST, S_BODY: begin
        // Pass-through lines: ready follows downstream only, never data_val.
        ip_tx_dst_val      = src_ip_tx_data_val;
        ip_tx_src_data_rdy = dst_ip_tx_rdy;
        ip_tx_dst_data     = {(state_q == S_FIRST) ? hdr_out : carry_q,
                              src_ip_tx_data[DATA_WIDTH-1 -: BODY_W]};
        // The last line ends the packet here only if its padding can absorb
        // the 20 bytes that would otherwise spill into a tail line.
        if (src_ip_tx_last && (src_ip_tx_padbytes >= PAD_HDR)) begin
          ip_tx_dst_last     = 1'b1;
          ip_tx_dst_padbytes = src_ip_tx_padbytes - PAD_HDR;
        end
        if (src_ip_tx_data_val && dst_ip_tx_rdy) begin
          carry_d = src_ip_tx_data[IP_HDR_W-1:0];
          if (!src_ip_tx_last) begin
            state_d = S_BODY;
          end else if (src_ip_tx_padbytes >= PAD_HDR) begin
            state_d = S_IDLE;
          end else begin
            state_d    = S_TAIL;
            tail_pad_d = PAD_TAIL_BASE + src_ip_tx_padbytes;
          end
        end
      end

      S_TAIL: begin
        ip_tx_dst_val      = 1'b1;
        ip_tx_dst_data     = {carry_q, {BODY_W{1'b0}}};
        ip_tx_dst_last     = 1'b1;
        ip_tx_dst_padbytes = tail_pad_q;
        if (dst_ip_tx_rdy) state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_ip_tx_hdr_insert.sv
// tb/tb_ip_tx_hdr_insert.sv - directed bench for ip_tx_hdr_insert
module tb_ip_tx_hdr_insert;

  logic         clk = 1'b0;
  logic         rst;
  logic         src_ip_tx_hdr_val;
  logic         ip_tx_src_hdr_rdy;
  logic [159:0] src_ip_tx_hdr;
  logic         src_ip_tx_data_val;
  logic         ip_tx_src_data_rdy;
  logic [255:0] src_ip_tx_data;
  logic         src_ip_tx_last;
  logic [4:0]   src_ip_tx_padbytes;
  logic         ip_tx_dst_val;
  logic         dst_ip_tx_rdy;
  logic [255:0] ip_tx_dst_data;
  logic         ip_tx_dst_last;
  logic [4:0]   ip_tx_dst_padbytes;

  always #5 clk = ~clk;

  ip_tx_hdr_insert dut (
    .clk                (clk),
    .rst                (rst),
    .src_ip_tx_hdr_val  (src_ip_tx_hdr_val),
    .ip_tx_src_hdr_rdy  (ip_tx_src_hdr_rdy),
    .src_ip_tx_hdr      (src_ip_tx_hdr),
    .src_ip_tx_data_val (src_ip_tx_data_val),
    .ip_tx_src_data_rdy (ip_tx_src_data_rdy),
    .src_ip_tx_data     (src_ip_tx_data),
    .src_ip_tx_last     (src_ip_tx_last),
    .src_ip_tx_padbytes (src_ip_tx_padbytes),
    .ip_tx_dst_val      (ip_tx_dst_val),
    .dst_ip_tx_rdy      (dst_ip_tx_rdy),
    .ip_tx_dst_data     (ip_tx_dst_data),
    .ip_tx_dst_last     (ip_tx_dst_last),
    .ip_tx_dst_padbytes (ip_tx_dst_padbytes)
  );

  localparam logic [159:0] H1 = 160'h4500_0073_0000_4000_4011_1234_c0a8_0001_c0a8_00c7;
  localparam logic [159:0] H2 = 160'h4500_0030_1c46_4000_4006_abcd_0a00_0001_0a00_0002;
`ifdef IP_TX_CHKSUM_EN
  localparam logic [15:0] CK1 = 16'hb861;
  localparam logic [15:0] CK2 = 16'h0a80;
`else
  localparam logic [15:0] CK1 = 16'h1234;
  localparam logic [15:0] CK2 = 16'habcd;
`endif

  int n_assert = 0;
  int n_fail   = 0;

  logic [7:0]   pb [0:255];
  logic [7:0]   eb [0:279];
  logic [255:0] first_line;
  logic [255:0] last_line;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic run_pkt(input logic [159:0] h, input logic [15:0] cks, input int n,
                         input int base, input bit rnd, input int exp_nout,
                         input logic [4:0] exp_lastpad);
    logic [159:0] hx;
    logic [255:0] ln;
    logic [255:0] pdata;
    logic         plast;
    logic [4:0]   ppad;
    int nin, in_idx, out_idx, cyc;
    bit hdr_done, pend, stall, dacc, hacc, oacc;
    hx = h;
    hx[79:64] = cks;
    for (int i = 0; i < 20; i++) eb[i] = hx[159-8*i -: 8];
    for (int i = 0; i < 256; i++) pb[i] = (i < n) ? 8'(base + i) : 8'h00;
    for (int i = 20; i < 280; i++) eb[i] = (i < 20 + n) ? pb[i-20] : 8'h00;
    nin = (n + 31) / 32;
    in_idx = 0; out_idx = 0; hdr_done = 0; pend = 0; stall = 0;
    pdata = '0; plast = 0; ppad = '0;
    for (cyc = 0; cyc < 400 && out_idx < exp_nout; cyc++) begin
      @(negedge clk);
      if (!pend && in_idx < nin) pend = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
      src_ip_tx_hdr_val  = !hdr_done;
      src_ip_tx_hdr      = h;
      src_ip_tx_data_val = pend;
      for (int b = 0; b < 32; b++) src_ip_tx_data[255-8*b -: 8] = pb[32*in_idx+b];
      src_ip_tx_last     = (in_idx == nin - 1);
      src_ip_tx_padbytes = src_ip_tx_last ? 5'(32*nin - n) : 5'd7;
      dst_ip_tx_rdy      = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      #1;
      if (cyc == 0) begin
        chk("idle_hdr_rdy", 256'(ip_tx_src_hdr_rdy), 256'(1));
        chk("idle_dst_val", 256'(ip_tx_dst_val), 256'(0));
        chk("idle_data_rdy", 256'(ip_tx_src_data_rdy), 256'(0));
      end else begin
        chk("busy_hdr_rdy", 256'(ip_tx_src_hdr_rdy), 256'(0));
      end
      if (stall) begin
        chk("stall_val", 256'(ip_tx_dst_val), 256'(1));
        chk("stall_data", ip_tx_dst_data, pdata);
        chk("stall_last", 256'(ip_tx_dst_last), 256'(plast));
        chk("stall_pad", 256'(ip_tx_dst_padbytes), 256'(ppad));
      end
      if (hdr_done && in_idx == nin && ip_tx_dst_val)
        chk("tail_data_rdy", 256'(ip_tx_src_data_rdy), 256'(0));
      oacc = ip_tx_dst_val && dst_ip_tx_rdy;
      if (oacc) begin
        for (int b = 0; b < 32; b++) ln[255-8*b -: 8] = eb[32*out_idx+b];
        chk($sformatf("line%0d_data", out_idx), ip_tx_dst_data, ln);
        chk($sformatf("line%0d_last", out_idx), 256'(ip_tx_dst_last),
            256'(out_idx == exp_nout - 1));
        chk($sformatf("line%0d_pad", out_idx), 256'(ip_tx_dst_padbytes),
            (out_idx == exp_nout - 1) ? 256'(exp_lastpad) : 256'(0));
        if (out_idx == 0) first_line = ip_tx_dst_data;
        last_line = ip_tx_dst_data;
      end
      stall = ip_tx_dst_val && !dst_ip_tx_rdy;
      pdata = ip_tx_dst_data;
      plast = ip_tx_dst_last;
      ppad  = ip_tx_dst_padbytes;
      dacc  = src_ip_tx_data_val && ip_tx_src_data_rdy;
      hacc  = src_ip_tx_hdr_val && ip_tx_src_hdr_rdy;
      @(posedge clk);
      if (hacc) hdr_done = 1;
      if (dacc) begin pend = 0; in_idx++; end
      if (oacc) out_idx++;
    end
    chk("pkt_lines_out", 256'(out_idx), 256'(exp_nout));
    chk("pkt_lines_in", 256'(in_idx), 256'(nin));
  endtask

  initial begin
    #300000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    src_ip_tx_hdr_val = 1'b0; src_ip_tx_hdr = '0;
    src_ip_tx_data_val = 1'b0; src_ip_tx_data = '0;
    src_ip_tx_last = 1'b0; src_ip_tx_padbytes = '0;
    dst_ip_tx_rdy = 1'b0;
    first_line = '0; last_line = '0;
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    chk("rst_hdr_rdy", 256'(ip_tx_src_hdr_rdy), 256'(1));
    chk("rst_data_rdy", 256'(ip_tx_src_data_rdy), 256'(0));
    chk("rst_dst_val", 256'(ip_tx_dst_val), 256'(0));
    chk("rst_dst_last", 256'(ip_tx_dst_last), 256'(0));
    chk("rst_dst_pad", 256'(ip_tx_dst_padbytes), 256'(0));
    rst = 1'b0;

    // one-line fit, checksum field
    run_pkt(H1, CK1, 12, 8'h10, 1'b0, 1, 5'd0);
    chk("cksum_bytes_10_11", 256'(first_line[175:160]), 256'(CK1));
    chk("fit_payload_bytes", 256'(first_line[95:0]), 256'(96'h10111213_14151617_18191a1b));

    // tail spill
    run_pkt(H2, CK2, 13, 8'h40, 1'b0, 2, 5'd31);
    chk("tail_byte0", 256'(last_line[255:248]), 256'(8'h4c));

    // multi-line, last input pad 24
    run_pkt(H1, CK1, 104, 8'h80, 1'b0, 4, 5'd4);

    // random backpressure and source gaps, back-to-back packets
    run_pkt(H2, CK2, 70, 8'h20, 1'b1, 3, 5'd6);
    run_pkt(H1, CK1, 45, 8'h60, 1'b1, 3, 5'd31);
    run_pkt(H2, CK2, 104, 8'h05, 1'b1, 4, 5'd4);

    // reset asserted while in BODY
    @(negedge clk);
    src_ip_tx_hdr_val = 1'b1; src_ip_tx_hdr = H2;
    src_ip_tx_data_val = 1'b1; src_ip_tx_data = {32{8'ha5}};
    src_ip_tx_last = 1'b0; src_ip_tx_padbytes = '0; dst_ip_tx_rdy = 1'b1;
    @(posedge clk);
    @(negedge clk);
    src_ip_tx_hdr_val = 1'b0;
    #1;
    chk("mid_first_val", 256'(ip_tx_dst_val), 256'(1));
    @(posedge clk);
    @(negedge clk); #1;
    chk("mid_body_val", 256'(ip_tx_dst_val), 256'(1));
    chk("mid_body_carry", 256'(ip_tx_dst_data[255:96]), 256'({20{8'ha5}}));
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk); #1;
    chk("mid_rst_dst_val", 256'(ip_tx_dst_val), 256'(0));
    chk("mid_rst_hdr_rdy", 256'(ip_tx_src_hdr_rdy), 256'(1));
    chk("mid_rst_data_rdy", 256'(ip_tx_src_data_rdy), 256'(0));
    rst = 1'b0;
    src_ip_tx_data_val = 1'b0;
    run_pkt(H2, CK2, 40, 8'hc0, 1'b0, 2, 5'd4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
